// File: rtl/core_arb_pkg.sv
// -----------------------------------------------------------------------------
// core_arb_pkg
//
// Shared types for the core memory arbiter:
//   arb_state_t : arbiter FSM states (IDLE, WAIT)
//   arb_port_t  : requester identity (PORT_FETCH, PORT_MEM)
//   MODE_READ / MODE_WRITE : request mode encodings
//   arb_req_t   : captured request payload {mode, addr, wdata, wstrb}
//   pick_fixed  : fixed-priority winner selection (data over fetch)
// -----------------------------------------------------------------------------
package core_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_MEM   = 1'b1
  } arb_port_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_req_t;

  // Data channel wins whenever it has a pending request.
  function automatic arb_port_t pick_fixed(input logic mem_valid);
    return mem_valid ? PORT_MEM : PORT_FETCH;
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// -----------------------------------------------------------------------------
// arb_req_slot
//
// One-entry capture slot for a single requester. A request pulse loads the
// payload and sets valid. A pulse that arrives while the slot already holds a
// request, or while this port owns the outstanding downstream transaction,
// is dropped and sets a sticky error flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req_en                 request pulse
//   i_mode/i_addr/i_wdata/i_wstrb  request payload
//   i_owned                  this port owns the transaction in flight
//   i_grant                  arbiter consumed the slot this cycle
//   o_valid                  slot holds a pending request
//   o_mode/o_addr/o_wdata/o_wstrb  held payload
//   o_err                    sticky protocol-violation flag
// -----------------------------------------------------------------------------
module arb_req_slot
  import core_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_en,
  input  logic        i_mode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_owned,
  input  logic        i_grant,
  output logic        o_valid,
  output logic        o_mode,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_err
);

  logic     r_valid;
  logic     r_err;
  arb_req_t r_req;
  logic     w_drop;

  // A second request before the response is a protocol violation.
  assign w_drop = i_req_en && (r_valid || i_owned);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      // NOTE: the payload only matters while valid is set, but it is cleared
      // too so the downstream bus shows zeros out of reset.
      r_req   <= '0;
    end else begin
      if (w_drop) begin
        r_err <= 1'b1;
      end
      // A grant implies the slot was valid, so any same-cycle pulse is a
      // drop; grant and load never coincide.
      if (i_grant) begin
        r_valid <= 1'b0;
      end else if (i_req_en && !w_drop) begin
        r_valid <= 1'b1;
        r_req   <= '{mode: i_mode, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb};
      end
    end
  end

  assign o_valid = r_valid;
  assign o_mode  = r_req.mode;
  assign o_addr  = r_req.addr;
  assign o_wdata = r_req.wdata;
  assign o_wstrb = r_req.wstrb;
  assign o_err   = r_err;

endmodule

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//
// Shares one downstream memory port between the instruction-fetch channel and
// the data (load/store) channel. Each channel's request pulse is captured in
// an arb_req_slot; one transaction at a time is granted downstream, and the
// downstream response is routed back to the owning channel as a one-cycle
// pulse with data held until that channel's next response.
//
// Configuration macro:
//   CORE_ARB_RR_EN  defined   : round-robin on ties (least recently granted
//                               port wins; pointer updates on every grant)
//                   undefined : fixed priority, data over fetch
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   fetch_request_enable, freq_*      fetch request pulse + payload
//   fetch_response_enable, fresp_data fetch response pulse + data
//   mem_request_enable, mreq_*        data request pulse + payload
//   mem_response_enable, mresp_data   data response pulse + data
//   dreq_enable, dreq_*               downstream request pulse + payload
//   dresp_enable, dresp_data          downstream response pulse + data
//   proto_err[1:0]                    sticky drop flags: [0] fetch, [1] data
// -----------------------------------------------------------------------------
module core_mem_arbiter
  import core_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // fetch channel
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  // data channel
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  // downstream port
  output logic        dreq_enable,
  output logic        dreq_mode,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_wstrb,
  input  logic        dresp_enable,
  input  logic [31:0] dresp_data,
  // status
  output logic [1:0]  proto_err
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  arb_state_t  r_state;
  arb_state_t  w_next_state;
  arb_port_t   r_owner;
  arb_port_t   w_winner;
  logic        w_grant;
  logic        w_resp;

  logic        w_fetch_valid;
  logic        w_fetch_err;
  logic        w_fetch_owned;
  logic        w_fetch_grant;
  arb_req_t    w_fetch_req;

  logic        w_mem_valid;
  logic        w_mem_err;
  logic        w_mem_owned;
  logic        w_mem_grant;
  arb_req_t    w_mem_req;

  arb_req_t    w_sel_req;

  logic        r_dreq_en;
  arb_req_t    r_dreq;
  logic        r_fresp_en;
  logic [31:0] r_fresp_data;
  logic        r_mresp_en;
  logic [31:0] r_mresp_data;

`ifdef CORE_ARB_RR_EN
  arb_port_t   r_last;
`endif

  // ---------------------------------------------------------------------------
  // Capture slots
  // ---------------------------------------------------------------------------
  assign w_fetch_owned = (r_state == WAIT) && (r_owner == PORT_FETCH);
  assign w_mem_owned   = (r_state == WAIT) && (r_owner == PORT_MEM);
  assign w_fetch_grant = w_grant && (w_winner == PORT_FETCH);
  assign w_mem_grant   = w_grant && (w_winner == PORT_MEM);

  arb_req_slot u_fetch_slot (
    .clk      (clk),
    .rst      (rst),
    .i_req_en (fetch_request_enable),
    .i_mode   (freq_mode),
    .i_addr   (freq_addr),
    .i_wdata  (freq_wdata),
    .i_wstrb  (freq_wstrb),
    .i_owned  (w_fetch_owned),
    .i_grant  (w_fetch_grant),
    .o_valid  (w_fetch_valid),
    .o_mode   (w_fetch_req.mode),
    .o_addr   (w_fetch_req.addr),
    .o_wdata  (w_fetch_req.wdata),
    .o_wstrb  (w_fetch_req.wstrb),
    .o_err    (w_fetch_err)
  );

  arb_req_slot u_mem_slot (
    .clk      (clk),
    .rst      (rst),
    .i_req_en (mem_request_enable),
    .i_mode   (mreq_mode),
    .i_addr   (mreq_addr),
    .i_wdata  (mreq_wdata),
    .i_wstrb  (mreq_wstrb),
    .i_owned  (w_mem_owned),
    .i_grant  (w_mem_grant),
    .o_valid  (w_mem_valid),
    .o_mode   (w_mem_req.mode),
    .o_addr   (w_mem_req.addr),
    .o_wdata  (w_mem_req.wdata),
    .o_wstrb  (w_mem_req.wstrb),
    .o_err    (w_mem_err)
  );

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_winner = pick_fixed(w_mem_valid);
`ifdef CORE_ARB_RR_EN
    // On a tie the port not granted most recently goes first.
    if (w_fetch_valid && w_mem_valid) begin
      w_winner = (r_last == PORT_MEM) ? PORT_FETCH : PORT_MEM;
    end
`endif
  end

  assign w_sel_req = (w_winner == PORT_MEM) ? w_mem_req : w_fetch_req;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        // A downstream response here has no owner and is ignored.
        if (w_fetch_valid || w_mem_valid) begin
          w_grant      = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // No timeout: hold until the downstream answers.
        if (dresp_enable) begin
          w_resp       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered downstream request and response routing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dreq_en    <= 1'b0;
      r_dreq       <= '0;
      r_owner      <= PORT_FETCH;
      r_fresp_en   <= 1'b0;
      r_fresp_data <= '0;
      r_mresp_en   <= 1'b0;
      r_mresp_data <= '0;
    end else begin
      r_dreq_en <= w_grant;
      if (w_grant) begin
        r_dreq  <= w_sel_req;
        r_owner <= w_winner;
      end

      r_fresp_en <= w_resp && (r_owner == PORT_FETCH);
      r_mresp_en <= w_resp && (r_owner == PORT_MEM);
      // Reads and writes alike forward the downstream data unchanged.
      if (w_resp && (r_owner == PORT_FETCH)) begin
        r_fresp_data <= dresp_data;
      end
      if (w_resp && (r_owner == PORT_MEM)) begin
        r_mresp_data <= dresp_data;
      end
    end
  end

`ifdef CORE_ARB_RR_EN
  // Reset to fetch-last so the data port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_FETCH;
    end else if (w_grant) begin
      r_last <= w_winner;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dreq_enable           = r_dreq_en;
  assign dreq_mode             = r_dreq.mode;
  assign dreq_addr             = r_dreq.addr;
  assign dreq_wdata            = r_dreq.wdata;
  assign dreq_wstrb            = r_dreq.wstrb;
  assign fetch_response_enable = r_fresp_en;
  assign fresp_data            = r_fresp_data;
  assign mem_response_enable   = r_mresp_en;
  assign mresp_data            = r_mresp_data;
  assign proto_err             = {w_mem_err, w_fetch_err};

endmodule

// File: tb/tb_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Directed bench for core_mem_arbiter. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point, so "cycle N" below is the
// interval following the N-th edge counted from the request pulse.
// Request and dresp pulses are one cycle wide: tick() drops them after the
// edge that samples them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_request_enable;
  logic        freq_mode;
  logic [31:0] freq_addr;
  logic [31:0] freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable;
  logic        mreq_mode;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        dreq_enable;
  logic        dreq_mode;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dresp_enable;
  logic [31:0] dresp_data;
  logic [1:0]  proto_err;

  int n_checks = 0;
  int n_errors = 0;

  core_mem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_request_enable  (fetch_request_enable),
    .freq_mode             (freq_mode),
    .freq_addr             (freq_addr),
    .freq_wdata            (freq_wdata),
    .freq_wstrb            (freq_wstrb),
    .fetch_response_enable (fetch_response_enable),
    .fresp_data            (fresp_data),
    .mem_request_enable    (mem_request_enable),
    .mreq_mode             (mreq_mode),
    .mreq_addr             (mreq_addr),
    .mreq_wdata            (mreq_wdata),
    .mreq_wstrb            (mreq_wstrb),
    .mem_response_enable   (mem_response_enable),
    .mresp_data            (mresp_data),
    .dreq_enable           (dreq_enable),
    .dreq_mode             (dreq_mode),
    .dreq_addr             (dreq_addr),
    .dreq_wdata            (dreq_wdata),
    .dreq_wstrb            (dreq_wstrb),
    .dresp_enable          (dresp_enable),
    .dresp_data            (dresp_data),
    .proto_err             (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and retire all single-cycle pulses.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      fetch_request_enable = 1'b0;
      mem_request_enable   = 1'b0;
      dresp_enable         = 1'b0;
    end
  endtask

  task automatic fetch_req(input logic [31:0] addr);
    fetch_request_enable = 1'b1;
    freq_mode            = 1'b0;
    freq_addr            = addr;
    freq_wdata           = 32'h0;
    freq_wstrb           = 4'h0;
  endtask

  task automatic mem_req(input logic mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_request_enable = 1'b1;
    mreq_mode          = mode;
    mreq_addr          = addr;
    mreq_wdata         = wdata;
    mreq_wstrb         = wstrb;
  endtask

  // Wait (bounded) for the next grant, check its address, answer it at once
  // and check the response lands on the expected port only.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic exp_mem, input logic [31:0] rdata);
    int k;
    k = 0;
    while (!dreq_enable && k < 10) begin
      tick();
      k++;
    end
    check({tag, "_issued"}, dreq_enable, 1'b1);
    check({tag, "_addr"}, dreq_addr, exp_addr);
    dresp_enable = 1'b1;
    dresp_data   = rdata;
    tick();
    if (exp_mem) begin
      check({tag, "_mresp"}, {mem_response_enable, fetch_response_enable, mresp_data},
            {1'b1, 1'b0, rdata});
    end else begin
      check({tag, "_fresp"}, {fetch_response_enable, mem_response_enable, fresp_data},
            {1'b1, 1'b0, rdata});
    end
  endtask

  initial begin
    rst                  = 1'b1;
    fetch_request_enable = 1'b0;
    freq_mode            = 1'b0;
    freq_addr            = 32'h0;
    freq_wdata           = 32'h0;
    freq_wstrb           = 4'h0;
    mem_request_enable   = 1'b0;
    mreq_mode            = 1'b0;
    mreq_addr            = 32'h0;
    mreq_wdata           = 32'h0;
    mreq_wstrb           = 4'h0;
    dresp_enable         = 1'b0;
    dresp_data           = 32'h0;
    tick(2);

    // ---------------- reset state ----------------
    check("rst_pulses", {dreq_enable, fetch_response_enable, mem_response_enable}, 3'b000);
    check("rst_dreq_payload", {dreq_mode, dreq_addr, dreq_wstrb}, 37'h0);
    check("rst_dreq_wdata", dreq_wdata, 32'h0);
    check("rst_resp_data", {fresp_data, mresp_data}, 64'h0);
    check("rst_proto_err", proto_err, 2'b00);
    rst = 1'b0;
    tick();

    // ---------------- single fetch read ----------------
    fetch_req(32'h100);                                  // cycle 0
    tick();                                              // cycle 1
    check("t1_c1_no_dreq", dreq_enable, 1'b0);
    tick();                                              // cycle 2
    check("t1_c2_dreq", {dreq_enable, dreq_mode, dreq_addr}, {1'b1, 1'b0, 32'h100});
    tick();                                              // cycle 3
    check("t1_c3_dreq_low", dreq_enable, 1'b0);
    tick(2);                                             // cycle 5
    dresp_enable = 1'b1;
    dresp_data   = 32'hDEADBEEF;
    tick();                                              // cycle 6
    check("t1_fresp", {fetch_response_enable, fresp_data}, {1'b1, 32'hDEADBEEF});
    check("t1_no_mresp", mem_response_enable, 1'b0);
    tick();                                              // cycle 7
    check("t1_fresp_hold", {fetch_response_enable, fresp_data}, {1'b0, 32'hDEADBEEF});

    // ---------------- simultaneous fetch + data write ----------------
    fetch_req(32'h200);                                  // cycle 0
    mem_req(1'b1, 32'h300, 32'h12345678, 4'hF);
    tick(2);                                             // cycle 2
    check("t2_data_first", {dreq_enable, dreq_mode, dreq_addr}, {1'b1, 1'b1, 32'h300});
    check("t2_write_payload", {dreq_wdata, dreq_wstrb}, {32'h12345678, 4'hF});
    tick();                                              // cycle 3
    dresp_enable = 1'b1;
    dresp_data   = 32'hA5A50001;
    tick();                                              // cycle 4
    check("t2_mresp", {mem_response_enable, fetch_response_enable, mresp_data},
          {1'b1, 1'b0, 32'hA5A50001});
    check("t2_c4_no_dreq", dreq_enable, 1'b0);
    mem_req(1'b0, 32'h340, 32'h0, 4'h0);                 // legal: same cycle as response
    tick();                                              // cycle 5
    check("t2_fetch_second", {dreq_enable, dreq_mode, dreq_addr}, {1'b1, 1'b0, 32'h200});
    dresp_enable = 1'b1;
    dresp_data   = 32'h0000F00D;
    tick();                                              // cycle 6
    check("t2_fresp", {fetch_response_enable, mem_response_enable, fresp_data},
          {1'b1, 1'b0, 32'h0000F00D});
    check("t2_mresp_hold", mresp_data, 32'hA5A50001);
    tick();                                              // cycle 7
    check("t2_rerequest_issued", {dreq_enable, dreq_addr}, {1'b1, 32'h340});
    dresp_enable = 1'b1;
    dresp_data   = 32'h00000077;
    tick();                                              // cycle 8
    check("t2_rerequest_resp", {mem_response_enable, mresp_data}, {1'b1, 32'h00000077});
    check("t2_no_proto_err", proto_err, 2'b00);

    // ---------------- tie arbitration ----------------
    // Fresh reset puts the round-robin pointer at fetch-last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Round 1: tie, data wins in both builds; fetch then follows.
    fetch_req(32'h210);
    mem_req(1'b0, 32'h310, 32'h0, 4'h0);
    tick();
    serve("tie1_win", 32'h310, 1'b1, 32'h11110001);
    serve("tie1_lose", 32'h210, 1'b0, 32'h11110002);
    // Round 2: fetch was granted last, so data wins in both builds.
    fetch_req(32'h220);
    mem_req(1'b0, 32'h320, 32'h0, 4'h0);
    tick();
    serve("tie2_win", 32'h320, 1'b1, 32'h22220001);
    serve("tie2_lose", 32'h220, 1'b0, 32'h22220002);
    // Solo data grant leaves data as most recently granted.
    mem_req(1'b0, 32'h330, 32'h0, 4'h0);
    tick();
    serve("solo_data", 32'h330, 1'b1, 32'h33330001);
    // Round 3: round-robin now favours fetch; fixed priority still data.
    fetch_req(32'h240);
    mem_req(1'b0, 32'h340, 32'h0, 4'h0);
    tick();
`ifdef CORE_ARB_RR_EN
    serve("tie3_win", 32'h240, 1'b0, 32'h44440001);
    serve("tie3_lose", 32'h340, 1'b1, 32'h44440002);
`else
    serve("tie3_win", 32'h340, 1'b1, 32'h44440001);
    serve("tie3_lose", 32'h240, 1'b0, 32'h44440002);
`endif

    // ---------------- protocol violation ----------------
    fetch_req(32'h400);                                  // cycle 0
    tick(2);                                             // cycle 2
    check("t4_first_issued", {dreq_enable, dreq_addr}, {1'b1, 32'h400});
    tick();                                              // cycle 3
    fetch_req(32'h480);                                  // fetch owns: dropped
    tick();                                              // cycle 4
    check("t4_proto_err", proto_err, 2'b01);
    tick();                                              // cycle 5
    dresp_enable = 1'b1;
    dresp_data   = 32'h44444444;
    tick();                                              // cycle 6
    check("t4_first_completes", {fetch_response_enable, fresp_data}, {1'b1, 32'h44444444});
    tick();                                              // cycle 7
    check("t4_c7_dropped", dreq_enable, 1'b0);
    tick();                                              // cycle 8
    check("t4_c8_dropped", dreq_enable, 1'b0);
    check("t4_sticky", proto_err, 2'b01);

    // ---------------- reset mid-transaction ----------------
    fetch_req(32'h500);                                  // cycle 0
    tick(2);                                             // cycle 2
    check("t5_issued", {dreq_enable, dreq_addr}, {1'b1, 32'h500});
    tick();                                              // cycle 3
    rst = 1'b1;
    tick();                                              // cycle 4
    rst = 1'b0;
    check("t5_reset_clears", {proto_err, dreq_enable}, 3'b000);
    tick();                                              // cycle 5
    dresp_enable = 1'b1;
    dresp_data   = 32'h55555555;
    tick();                                              // cycle 6
    check("t5_no_resp", {fetch_response_enable, mem_response_enable, dreq_enable}, 3'b000);
    check("t5_resp_data", {fresp_data, mresp_data}, 64'h0);
    fetch_req(32'h600);                                  // new cycle 0
    tick(2);                                             // cycle 2
    check("t5_next_issued", {dreq_enable, dreq_addr}, {1'b1, 32'h600});
    dresp_enable = 1'b1;
    dresp_data   = 32'h0BADF00D;
    tick();
    check("t5_next_resp", {fetch_response_enable, fresp_data}, {1'b1, 32'h0BADF00D});

    // ---------------- stray response while idle ----------------
    tick();
    dresp_enable = 1'b1;
    dresp_data   = 32'hFFFFFFFF;
    tick();
    check("t6_no_pulses", {fetch_response_enable, mem_response_enable, dreq_enable}, 3'b000);
    check("t6_data_held", {fresp_data, mresp_data}, {32'h0BADF00D, 32'h0});
    check("t6_dreq_held", {dreq_addr, proto_err}, {32'h600, 2'b00});
    fetch_req(32'h700);                                  // FSM still IDLE
    tick(2);
    check("t6_still_idle", {dreq_enable, dreq_addr}, {1'b1, 32'h700});
    dresp_enable = 1'b1;
    dresp_data   = 32'h77777777;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one downstream memory port between the core's instruction-fetch channel and its data (load/store) channel. Each requester issues single-cycle request pulses and receives a single-cycle response pulse. The arbiter captures each pulse in a one-entry slot, grants one transaction at a time to the downstream port, and routes the response back to the owner. It sits between `core` and the memory/cache subsystem.

## Interface
- No parameters; all widths fixed at 32-bit address/data and 4-bit strobe.
- `clk`  in  1  the single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_request_enable`, `freq_mode`, `freq_addr[31:0]`, `freq_wdata[31:0]`, `freq_wstrb[3:0]`  in  fetch request pulse and payload. Mode 0 = read, 1 = write.
- `fetch_response_enable`  out  1  fetch response pulse.
- `fresp_data`  out  32  fetch response data.
- `mem_request_enable`, `mreq_mode`, `mreq_addr[31:0]`, `mreq_wdata[31:0]`, `mreq_wstrb[3:0]`  in  data request pulse and payload.
- `mem_response_enable`  out  1  data response pulse.
- `mresp_data`  out  32  data response data.
- `dreq_enable`, `dreq_mode`, `dreq_addr[31:0]`, `dreq_wdata[31:0]`, `dreq_wstrb[3:0]`  out  downstream request pulse and payload.
- `dresp_enable`  in  1  downstream response pulse.
- `dresp_data`  in  32  downstream response data.
- `proto_err`  out  2  sticky error flags: [0] fetch, [1] data.

## Operation
- Each port has a capture slot holding `{valid, mode, addr, wdata, wstrb}`. A request pulse loads the slot and sets `valid`.
- FSM states: IDLE, WAIT.
- IDLE with at least one valid slot:
  - select the winner;
  - register its payload onto `dreq_*` and pulse `dreq_enable` for exactly 1 cycle;
  - clear the winner's slot `valid`;
  - record `owner`;
  - go to WAIT.
- IDLE with no valid slot: stay in IDLE.
- WAIT with `dresp_enable`:
  - latch `dresp_data` into the owner's response register;
  - pulse the owner's `*_response_enable` next cycle;
  - go to IDLE.
- WAIT without `dresp_enable`: hold. There is no timeout.
- Arbitration without the macro is fixed priority: data beats fetch.
- Protocol rule: a requester issues at most one request before receiving its response. If a request pulse arrives while that port's slot is valid or the port owns the outstanding transaction:
  - the request is dropped;
  - the slot is unchanged;
  - the port's `proto_err` bit sets and holds until reset.
- `dresp_enable` in IDLE is ignored. No output changes.
- Write transactions also complete via `dresp_enable`; response data is forwarded as-is.
- Reset values: all `*_enable` outputs 0; all data/addr/strb outputs 0; `proto_err` 0; slots invalid; FSM IDLE; round-robin pointer set to fetch-last (so data wins the first tie).
- Reset mid-transaction: the outstanding transaction is abandoned, and a later `dresp_enable` is ignored (FSM is in IDLE).

## Timing
- Request pulse in cycle 0 → slot valid in cycle 1 → `dreq_enable` high in cycle 2 (if not blocked).
- `dresp_enable` in cycle r → requester response pulse and data valid in cycle r+1.
- Earliest next grant is decided in cycle r+1, so the next `dreq_enable` is in cycle r+2.
- Simultaneous pulses on both ports in one cycle: both are captured. The winner issues in cycle 2; the loser issues 2 cycles after the winner's `dresp_enable`.
- A request arriving in the same cycle its port's response pulses is legal and is captured.
- `dreq_*` payload is valid only in the `dreq_enable` cycle. `*resp_data` holds its value until the next response on that port.

## Configuration
- `CORE_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port not granted most recently wins; the pointer updates on every grant.
- Undefined: fixed priority, data over fetch. The pointer logic is not compiled.

## Structure
- Package `core_arb_pkg` contains:
  - `arb_state_t` {IDLE, WAIT};
  - `arb_port_t` {PORT_FETCH, PORT_MEM};
  - `MODE_READ` = 1'b0, `MODE_WRITE` = 1'b1;
  - struct `arb_req_t` {mode, addr, wdata, wstrb}.
- Sub-module `arb_req_slot` implements the one-entry capture slot with drop and error detection. It is instantiated twice.

## Test plan
- Single fetch read, addr 0x100, `dresp_data` 0xDEADBEEF after 3 cycles → `dreq_enable` in cycle 2 with addr 0x100, mode 0; `fetch_response_enable` with 0xDEADBEEF one cycle after `dresp_enable`; no `mem_response_enable`.
- Simultaneous fetch 0x200 and data write 0x300 (wdata 0x12345678, wstrb 0xF) → data is issued first; fetch is issued 2 cycles after the first `dresp_enable`. Each response is routed to the correct port.
- With `CORE_ARB_RR_EN`, three back-to-back ties (both ports re-request after each response) → grant order data, fetch, data. Without the macro → data on every tie.
- Second fetch pulse while the first is outstanding → dropped; `proto_err` = 2'b01 and sticky; the first transaction completes normally.
- Reset asserted in WAIT, then `dresp_enable` 2 cycles later → no response pulse on either port; next fetch request issues in cycle 2 after it.
- `dresp_enable` with no request outstanding → all outputs unchanged.
